rvv_backend_div_rs_fifo: RTL and testbench

//  Reservation-station FIFO for the DIV pipe. Dispatch pushes up to NUM_PUSH DIV uops per cycle in order.
//  The divide units pop up to NUM_POP uops per cycle from the head, as a thermometer (pop[i] requires pop[i-1]).

---
 rtl/rvv_backend_div_rs_fifo_if.sv | 31 +++
 rtl/rvv_backend_div_rs_fifo.sv | 101 ++++++++++
 tb/tb_rvv_backend_div_rs_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rvv_backend_div_rs_fifo_if.sv
// Bundle of the dispatch-push / DIV-pop handshake and status signals around the DIV reservation-station FIFO.
// master = dispatch + DIV units side, slave = the FIFO itself.
interface rvv_backend_div_rs_fifo_if #(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 128,
  parameter int NUM_PUSH = 2,
  parameter int NUM_POP  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [NUM_PUSH-1:0]        push_valid;
  logic [NUM_PUSH*DATA_W-1:0] push_data;
  logic [NUM_PUSH-1:0]        push_ready;
  logic [NUM_POP-1:0]         pop;
  logic [NUM_POP*DATA_W-1:0]  pop_data;
  logic                       fifo_empty;
  logic [NUM_POP-1:0]         fifo_almost_empty;
  logic                       fifo_full;
  logic [CNT_W-1:0]           count;
  logic                       trap_flush_rvv;

  modport master (
    output push_valid, push_data, pop, trap_flush_rvv,
    input  push_ready, pop_data, fifo_empty, fifo_almost_empty, fifo_full, count
  );

  modport slave (
    input  push_valid, push_data, pop, trap_flush_rvv,
    output push_ready, pop_data, fifo_empty, fifo_almost_empty, fifo_full, count
  );
endinterface

// File: rtl/rvv_backend_div_rs_fifo.sv
// DIV reservation-station FIFO: multi-lane in-order push from dispatch, thermometer multi-lane pop
// from the head by the DIV units, full flush on trap.
module rvv_backend_div_rs_fifo #(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 128,
  parameter int NUM_PUSH = 2,
  parameter int NUM_POP  = 2
) (
  input logic                     clk,
  input logic                     rst,
  rvv_backend_div_rs_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count_q;

  logic [NUM_PUSH-1:0] push_ready_c;
  logic [NUM_PUSH-1:0] push_fire;
  logic [NUM_POP-1:0]  almost_empty_c;
  logic [NUM_POP-1:0]  pop_eff;
  logic [CNT_W-1:0]    n_push;
  logic [CNT_W-1:0]    n_pop;
  logic [PTR_W-1:0]    wr_addr [NUM_PUSH];
  logic [PTR_W-1:0]    rd_addr [NUM_POP];

  // Readiness and occupancy come from the registered count only: pops in the
  // same cycle never lend credit to pushes.
  always_comb begin
    push_ready_c   = '0;
    push_fire      = '0;
    almost_empty_c = '0;
    pop_eff        = '0;
    n_push         = '0;
    n_pop          = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      push_ready_c[i] = (DEPTH_C - count_q) > CNT_W'(i);
      push_fire[i]    = bus.push_valid[i] & push_ready_c[i] & ~bus.trap_flush_rvv;
      n_push          = n_push + CNT_W'(push_fire[i]);
      wr_addr[i]      = wptr + PTR_W'(i);
    end
    for (int i = 0; i < NUM_POP; i++) begin
      almost_empty_c[i] = count_q <= CNT_W'(i);
      pop_eff[i]        = bus.pop[i] & ~almost_empty_c[i];
      n_pop             = n_pop + CNT_W'(pop_eff[i]);
      rd_addr[i]        = rptr + PTR_W'(i);
    end
  end

  // NOTE: entry storage has no reset; only pointers and count define which entries are live,
  // so resetting the array would cost a reset net on every data flop for no functional gain.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (push_fire[i]) mem[wr_addr[i]] <= bus.push_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else if (bus.trap_flush_rvv) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      wptr    <= wptr + PTR_W'(n_push);
      rptr    <= rptr + PTR_W'(n_pop);
      count_q <= count_q + n_push - n_pop;
    end
  end

  always_comb begin
    bus.pop_data = '0;
    for (int i = 0; i < NUM_POP; i++) begin
      bus.pop_data[i*DATA_W +: DATA_W] = mem[rd_addr[i]];
    end
  end

  assign bus.push_ready        = push_ready_c;
  assign bus.fifo_almost_empty = almost_empty_c;
  assign bus.fifo_empty        = (count_q == '0);
  assign bus.fifo_full         = (count_q == DEPTH_C);
  assign bus.count             = count_q;

  a_push_therm: assert property (@(posedge clk) disable iff (rst)
    ((bus.push_valid & (bus.push_valid + NUM_PUSH'(1))) == '0));
  a_pop_therm: assert property (@(posedge clk) disable iff (rst)
    ((bus.pop & (bus.pop + NUM_POP'(1))) == '0));
  a_push_ready: assert property (@(posedge clk) disable iff (rst)
    ((push_fire & ~push_ready_c) == '0));
  // Over-popping is illegal upstream but is masked off here, so it is reported rather than fatal.
  a_pop_occupied: assert property (@(posedge clk) disable iff (rst)
    ((bus.pop & almost_empty_c) == '0))
    else $warning("pop beyond occupied entries ignored");
endmodule

// File: tb/tb_rvv_backend_div_rs_fifo.sv
// Bench for rvv_backend_div_rs_fifo: directed vector table for the reset/fill/drain/wrap/flush cases,
// then randomized traffic against a queue-based reference model.
module tb_rvv_backend_div_rs_fifo;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rvv_backend_div_rs_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_PUSH(2), .NUM_POP(2)) bus ();

  rvv_backend_div_rs_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_PUSH(2), .NUM_POP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] pv;
    logic [1:0] pop;
    logic       fl;
    logic [7:0] t0;
    logic [7:0] t1;
    int         cnt;
    logic [1:0] rdy;
    logic [1:0] ae;
    logic       full;
    logic [1:0] chk;
    logic [7:0] p0;
    logic [7:0] p1;
  } vec_t;

  vec_t tbl [26];
  logic [DATA_W-1:0] model_q [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [7:0] t);
    return {16{t}};
  endfunction

  function automatic logic [1:0] therm(input int n);
    return (n >= 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
  endfunction

  task automatic drive(input logic [1:0] pv, input logic [1:0] pop, input logic fl,
                       input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    bus.push_valid     = pv;
    bus.pop            = pop;
    bus.trap_flush_rvv = fl;
    bus.push_data      = {d1, d0};
  endtask

  // Reference: a plain queue; acceptance limited by free space, pops limited by occupancy.
  task automatic model_step(input logic [1:0] pv, input logic [1:0] pop, input logic fl,
                            input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    int space, nacc, npop;
    space = DEPTH - model_q.size();
    nacc  = int'(pv[0]) + int'(pv[1]);
    if (nacc > space) nacc = space;
    npop  = int'(pop[0]) + int'(pop[1]);
    if (npop > model_q.size()) npop = model_q.size();
    if (fl) begin
      model_q.delete();
    end else begin
      repeat (npop) void'(model_q.pop_front());
      if (nacc >= 1) model_q.push_back(d0);
      if (nacc >= 2) model_q.push_back(d1);
    end
  endtask

  task automatic check_model(input int cyc);
    int n;
    n = model_q.size();
    check($sformatf("rnd%0d_count", cyc), 256'(bus.count), 256'(n));
    check($sformatf("rnd%0d_empty", cyc), 256'(bus.fifo_empty), 256'(n == 0));
    check($sformatf("rnd%0d_full", cyc), 256'(bus.fifo_full), 256'(n == DEPTH));
    check($sformatf("rnd%0d_ae", cyc), 256'(bus.fifo_almost_empty), 256'({n <= 1, n <= 0}));
    check($sformatf("rnd%0d_ready", cyc), 256'(bus.push_ready), 256'({(DEPTH - n) > 1, (DEPTH - n) > 0}));
    for (int i = 0; i < 2; i++) begin
      if (i < n) check($sformatf("rnd%0d_pop_data%0d", cyc, i),
                       256'(bus.pop_data[i*DATA_W +: DATA_W]), 256'(model_q[i]));
    end
  endtask

  initial begin
    //            pv     pop    fl    t0     t1     cnt rdy    ae     full  chk    p0     p1
    tbl[0]  = '{2'b11, 2'b00, 1'b0, 8'd0,  8'd1,  2, 2'b11, 2'b00, 1'b0, 2'b11, 8'd0,  8'd1};
    tbl[1]  = '{2'b11, 2'b00, 1'b0, 8'd2,  8'd3,  4, 2'b11, 2'b00, 1'b0, 2'b11, 8'd0,  8'd1};
    tbl[2]  = '{2'b11, 2'b00, 1'b0, 8'd4,  8'd5,  6, 2'b11, 2'b00, 1'b0, 2'b11, 8'd0,  8'd1};
    tbl[3]  = '{2'b11, 2'b00, 1'b0, 8'd6,  8'd7,  8, 2'b00, 2'b00, 1'b1, 2'b11, 8'd0,  8'd1};
    tbl[4]  = '{2'b00, 2'b11, 1'b0, 8'd0,  8'd0,  6, 2'b11, 2'b00, 1'b0, 2'b11, 8'd2,  8'd3};
    tbl[5]  = '{2'b00, 2'b11, 1'b0, 8'd0,  8'd0,  4, 2'b11, 2'b00, 1'b0, 2'b11, 8'd4,  8'd5};
    tbl[6]  = '{2'b00, 2'b11, 1'b0, 8'd0,  8'd0,  2, 2'b11, 2'b00, 1'b0, 2'b11, 8'd6,  8'd7};
    tbl[7]  = '{2'b00, 2'b11, 1'b0, 8'd0,  8'd0,  0, 2'b11, 2'b11, 1'b0, 2'b00, 8'd0,  8'd0};
    tbl[8]  = '{2'b01, 2'b00, 1'b0, 8'd8,  8'd0,  1, 2'b11, 2'b10, 1'b0, 2'b01, 8'd8,  8'd0};
    tbl[9]  = '{2'b00, 2'b11, 1'b0, 8'd0,  8'd0,  0, 2'b11, 2'b11, 1'b0, 2'b00, 8'd0,  8'd0};
    tbl[10] = '{2'b11, 2'b00, 1'b0, 8'd9,  8'd10, 2, 2'b11, 2'b00, 1'b0, 2'b11, 8'd9,  8'd10};
    tbl[11] = '{2'b11, 2'b00, 1'b0, 8'd11, 8'd12, 4, 2'b11, 2'b00, 1'b0, 2'b11, 8'd9,  8'd10};
    tbl[12] = '{2'b11, 2'b00, 1'b0, 8'd13, 8'd14, 6, 2'b11, 2'b00, 1'b0, 2'b11, 8'd9,  8'd10};
    tbl[13] = '{2'b01, 2'b00, 1'b0, 8'd15, 8'd0,  7, 2'b01, 2'b00, 1'b0, 2'b11, 8'd9,  8'd10};
    tbl[14] = '{2'b11, 2'b01, 1'b0, 8'd16, 8'd17, 7, 2'b01, 2'b00, 1'b0, 2'b11, 8'd10, 8'd11};
    tbl[15] = '{2'b00, 2'b11, 1'b0, 8'd0,  8'd0,  5, 2'b11, 2'b00, 1'b0, 2'b11, 8'd12, 8'd13};
    tbl[16] = '{2'b00, 2'b11, 1'b0, 8'd0,  8'd0,  3, 2'b11, 2'b00, 1'b0, 2'b11, 8'd14, 8'd15};
    tbl[17] = '{2'b00, 2'b01, 1'b0, 8'd0,  8'd0,  2, 2'b11, 2'b00, 1'b0, 2'b11, 8'd15, 8'd16};
    tbl[18] = '{2'b11, 2'b00, 1'b0, 8'hA0, 8'hA1, 4, 2'b11, 2'b00, 1'b0, 2'b11, 8'd15, 8'd16};
    tbl[19] = '{2'b00, 2'b11, 1'b0, 8'd0,  8'd0,  2, 2'b11, 2'b00, 1'b0, 2'b11, 8'hA0, 8'hA1};
    tbl[20] = '{2'b00, 2'b11, 1'b0, 8'd0,  8'd0,  0, 2'b11, 2'b11, 1'b0, 2'b00, 8'd0,  8'd0};
    tbl[21] = '{2'b11, 2'b00, 1'b0, 8'd20, 8'd21, 2, 2'b11, 2'b00, 1'b0, 2'b11, 8'd20, 8'd21};
    tbl[22] = '{2'b11, 2'b00, 1'b0, 8'd22, 8'd23, 4, 2'b11, 2'b00, 1'b0, 2'b11, 8'd20, 8'd21};
    tbl[23] = '{2'b01, 2'b00, 1'b0, 8'd24, 8'd0,  5, 2'b11, 2'b00, 1'b0, 2'b11, 8'd20, 8'd21};
    tbl[24] = '{2'b11, 2'b11, 1'b1, 8'd25, 8'd26, 0, 2'b11, 2'b11, 1'b0, 2'b00, 8'd0,  8'd0};
    tbl[25] = '{2'b01, 2'b00, 1'b0, 8'd27, 8'd0,  1, 2'b11, 2'b10, 1'b0, 2'b01, 8'd27, 8'd0};

    drive(2'b00, 2'b00, 1'b0, '0, '0);
    #2;
    check("reset_count", 256'(bus.count), 256'(0));
    check("reset_empty", 256'(bus.fifo_empty), 256'(1));
    check("reset_ae", 256'(bus.fifo_almost_empty), 256'(2'b11));
    check("reset_full", 256'(bus.fifo_full), 256'(0));
    check("reset_ready", 256'(bus.push_ready), 256'(2'b11));

    // Pushes presented while reset is held must not land.
    drive(2'b11, 2'b00, 1'b0, mk(8'hEE), mk(8'hEF));
    @(posedge clk);
    #1;
    check("reset_hold_count", 256'(bus.count), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 26; k++) begin
      drive(tbl[k].pv, tbl[k].pop, tbl[k].fl, mk(tbl[k].t0), mk(tbl[k].t1));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", k), 256'(bus.count), 256'(tbl[k].cnt));
      check($sformatf("v%0d_ready", k), 256'(bus.push_ready), 256'(tbl[k].rdy));
      check($sformatf("v%0d_ae", k), 256'(bus.fifo_almost_empty), 256'(tbl[k].ae));
      check($sformatf("v%0d_empty", k), 256'(bus.fifo_empty), 256'(tbl[k].ae[0]));
      check($sformatf("v%0d_full", k), 256'(bus.fifo_full), 256'(tbl[k].full));
      if (tbl[k].chk[0]) check($sformatf("v%0d_pop_data0", k),
                               256'(bus.pop_data[0 +: DATA_W]), 256'(mk(tbl[k].p0)));
      if (tbl[k].chk[1]) check($sformatf("v%0d_pop_data1", k),
                               256'(bus.pop_data[DATA_W +: DATA_W]), 256'(mk(tbl[k].p1)));
    end

    // Push-to-pop latency: a uop pushed into an empty FIFO is not visible before the push edge.
    drive(2'b00, 2'b11, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    drive(2'b01, 2'b00, 1'b0, mk(8'h5A), '0);
    check("latency_empty_before_edge", 256'(bus.fifo_empty), 256'(1));
    @(posedge clk);
    #1;
    check("latency_visible_after_edge", 256'(bus.pop_data[0 +: DATA_W]), 256'(mk(8'h5A)));
    model_q.delete();
    model_q.push_back(mk(8'h5A));

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [1:0] pv, pop;
      logic fl;
      logic [DATA_W-1:0] d0, d1;
      int np;
      pv  = therm($urandom_range(0, 2));
      np  = $urandom_range(0, 2);
      if (np > model_q.size()) np = model_q.size();
      pop = therm(np);
      fl  = ($urandom_range(0, 63) == 0);
      d0  = {$urandom, $urandom, $urandom, $urandom};
      d1  = {$urandom, $urandom, $urandom, $urandom};
      drive(pv, pop, fl, d0, d1);
      @(posedge clk);
      #1;
      model_step(pv, pop, fl, d0, d1);
      check_model(cyc);
    end

    drive(2'b00, 2'b00, 1'b0, '0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
